ibex_fetch_buf: RTL and testbench

IBEX_FETCH_BUF -- requirements
Module: ibex_fetch_buf

---
 rtl/ibex_fetch_aligner.sv | 37 +++
 rtl/ibex_fetch_buf.sv | 162 ++++++++++++++++
 tb/tb_ibex_fetch_buf.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_fetch_aligner.sv
// Half-word aligner: picks the instruction at the current PC out of the head
// word and the following word, and flags compressed / erroneous instructions.
module ibex_fetch_aligner (
    input  logic        addr1,
    input  logic        head_valid,
    input  logic [31:0] head_rdata,
    input  logic        head_err,
    input  logic        next_valid,
    input  logic [15:0] next_lo,
    input  logic        next_err,
    output logic        valid,
    output logic [31:0] rdata,
    output logic        err,
    output logic        err_plus2,
    output logic        compressed
);

    always_comb begin
        valid      = 1'b0;
        rdata      = head_rdata;
        err        = head_err;
        err_plus2  = 1'b0;
        compressed = 1'b0;
        if (!addr1) begin
            compressed = (head_rdata[1:0] != 2'b11) && !head_err;
            valid      = head_valid;
        end else begin
            rdata      = {next_lo, head_rdata[31:16]};
            compressed = (head_rdata[17:16] != 2'b11) && !head_err;
            valid      = head_valid && (compressed || next_valid);
            // A compressed upper half never touches the next word.
            err        = compressed ? head_err : (head_err | next_err);
            err_plus2  = !compressed && !head_err && next_err;
        end
    end

endmodule

// File: rtl/ibex_fetch_buf.sv
// Instruction fetch buffer: shift FIFO of fetched words with zero-latency
// bypass, PC tracking and an optional PC checkpoint for restore.
module ibex_fetch_buf #(
    parameter int unsigned  NUM_REQS = 2,
    parameter bit           ResetAll = 1'b0,
    parameter bit           BackupEn = 1'b1,
    localparam int unsigned DEPTH    = NUM_REQS + 1,
    localparam int unsigned LvlW     = $clog2(DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                backup_i,
    input  logic                restore_i,
    output logic [NUM_REQS-1:0] busy_o,
    output logic [LvlW-1:0]     level_o,
    output logic                overflow_o,
    input  logic                in_valid_i,
    input  logic [31:0]         in_addr_i,
    input  logic [31:0]         in_rdata_i,
    input  logic                in_err_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [31:0]         out_addr_o,
    output logic [31:0]         out_rdata_o,
    output logic                out_err_o,
    output logic                out_err_plus2_o
);

    // out_valid_o/out_ready_i: an instruction transfers in every cycle where both
    // are high; out_ready_i may depend on out_valid_o, never the reverse.
    // in_valid_i has no ready: a word arriving while full is dropped.

    logic [DEPTH-1:0]       valid_q, valid_w, valid_d;
    logic [DEPTH-1:0][31:0] rdata_q, rdata_w, rdata_d;
    logic [DEPTH-1:0]       err_q, err_w, err_d;
    logic [31:0]            pc_q, pc_d, backup_q;
    logic                   overflow_q;
    logic                   head_valid, head_err, next_valid, next_err;
    logic [31:0]            head_rdata;
    logic [15:0]            next_lo;
    logic                   compressed, handshake, pop, push, full, flush, restore_en;
    logic                   unused_addr0;

    assign unused_addr0 = in_addr_i[0];
    assign restore_en   = BackupEn & restore_i;
    assign flush        = clear_i | restore_en;
    assign full         = valid_q[DEPTH-1];
    assign push         = in_valid_i & ~full;

    // Incoming word stands in for the first empty slot among entries 0 and 1.
    assign head_valid = valid_q[0] | in_valid_i;
    assign head_rdata = valid_q[0] ? rdata_q[0] : in_rdata_i;
    assign head_err   = valid_q[0] ? err_q[0] : in_err_i;
    assign next_valid = valid_q[1] | (valid_q[0] & in_valid_i);
    assign next_lo    = valid_q[1] ? rdata_q[1][15:0] : in_rdata_i[15:0];
    assign next_err   = valid_q[1] ? err_q[1] : in_err_i;

    ibex_fetch_aligner u_aligner (
        .addr1      (pc_q[1]),
        .head_valid (head_valid),
        .head_rdata (head_rdata),
        .head_err   (head_err),
        .next_valid (next_valid),
        .next_lo    (next_lo),
        .next_err   (next_err),
        .valid      (out_valid_o),
        .rdata      (out_rdata_o),
        .err        (out_err_o),
        .err_plus2  (out_err_plus2_o),
        .compressed (compressed)
    );

    assign handshake = out_valid_o & out_ready_i;
    // An aligned compressed instruction leaves the upper half for the next cycle.
    assign pop       = handshake & (~compressed | pc_q[1]);

    always_comb begin : write_stage
        logic prev;
        valid_w = valid_q;
        rdata_w = rdata_q;
        err_w   = err_q;
        prev    = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (push && !valid_q[i] && prev) begin
                valid_w[i] = 1'b1;
                rdata_w[i] = in_rdata_i;
                err_w[i]   = in_err_i;
            end
            prev = valid_q[i];
        end
    end

    always_comb begin
        valid_d = valid_w;
        rdata_d = rdata_w;
        err_d   = err_w;
        if (pop) begin
            valid_d = valid_w >> 1;
            for (int i = 0; i < DEPTH - 1; i++) begin
                rdata_d[i] = rdata_w[i+1];
                err_d[i]   = err_w[i+1];
            end
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (clear_i) begin
            pc_d = {in_addr_i[31:1], 1'b0};
        end else if (restore_en) begin
            pc_d = backup_q;
        end else if (handshake) begin
            pc_d = pc_q + (compressed ? 32'd2 : 32'd4);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q    <= '0;
            pc_q       <= '0;
            backup_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            if (BackupEn && backup_i && !restore_i) begin
                backup_q <= pc_d;
            end
            if (clear_i) begin
                overflow_q <= 1'b0;
            end else if (in_valid_i && full && !restore_en) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (ResetAll && !rst_ni) begin
            rdata_q <= '0;
            err_q   <= '0;
        end else begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        level_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            level_o = level_o + LvlW'(valid_q[i]);
        end
    end

    assign busy_o     = valid_q[DEPTH-1 -: NUM_REQS];
    assign overflow_o = overflow_q;
    assign out_addr_o = pc_q;

endmodule

// File: tb/tb_ibex_fetch_buf.sv
// Bench for ibex_fetch_buf: directed scenarios plus randomized traffic checked
// against a queue-based model of the fetch buffer.
module tb_ibex_fetch_buf;

    localparam int NUM_REQS = 2;
    localparam int DEPTH    = NUM_REQS + 1;
    localparam int LVL_W    = $clog2(DEPTH + 1);

    logic                clk_i = 1'b0;
    logic                rst_ni, clear_i, backup_i, restore_i;
    logic [NUM_REQS-1:0] busy_o;
    logic [LVL_W-1:0]    level_o;
    logic                overflow_o;
    logic                in_valid_i, in_err_i, out_ready_i;
    logic [31:0]         in_addr_i, in_rdata_i;
    logic                out_valid_o, out_err_o, out_err_plus2_o;
    logic [31:0]         out_addr_o, out_rdata_o;

    int checks = 0;
    int errors = 0;

    // Model storage: {err, word} per buffered fetch response.
    logic [32:0] exp_q[$];

    ibex_fetch_buf u_dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .clear_i         (clear_i),
        .backup_i        (backup_i),
        .restore_i       (restore_i),
        .busy_o          (busy_o),
        .level_o         (level_o),
        .overflow_o      (overflow_o),
        .in_valid_i      (in_valid_i),
        .in_addr_i       (in_addr_i),
        .in_rdata_i      (in_rdata_i),
        .in_err_i        (in_err_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_addr_o      (out_addr_o),
        .out_rdata_o     (out_rdata_o),
        .out_err_o       (out_err_o),
        .out_err_plus2_o (out_err_plus2_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        clear_i     = 1'b0;
        backup_i    = 1'b0;
        restore_i   = 1'b0;
        in_valid_i  = 1'b0;
        in_addr_i   = 32'h0;
        in_rdata_i  = 32'h0;
        in_err_i    = 1'b0;
        out_ready_i = 1'b0;
    endtask

    task automatic do_clear(input logic [31:0] addr);
        clear_i   = 1'b1;
        in_addr_i = addr;
        tick();
        clear_i   = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] data, input logic err);
        in_valid_i = 1'b1;
        in_rdata_i = data;
        in_err_i   = err;
        tick();
        in_valid_i = 1'b0;
        in_err_i   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 1'b0;
        tick();
        tick();
        #2;
        checks++; if (level_o !== 0) begin errors++; $display("FAIL reset_level: got %0d want 0", level_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid_o); end
        checks++; if (out_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", out_addr_o); end
        checks++; if (busy_o !== '0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_compressed();
        do_clear(32'h100);
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        in_rdata_i  = 32'h0000_4501;
        #2;
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL cmp_bypass_valid: got %b want 1", out_valid_o); end
        checks++; if (out_addr_o !== 32'h100) begin errors++; $display("FAIL cmp_addr0: got %h want 100", out_addr_o); end
        checks++; if (out_rdata_o !== 32'h0000_4501) begin errors++; $display("FAIL cmp_rdata0: got %h want 00004501", out_rdata_o); end
        tick();
        in_valid_i = 1'b0;
        in_rdata_i = 32'h0;
        #2;
        checks++; if (level_o !== 1) begin errors++; $display("FAIL cmp_no_pop_level: got %0d want 1", level_o); end
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL cmp_valid1: got %b want 1", out_valid_o); end
        checks++; if (out_addr_o !== 32'h102) begin errors++; $display("FAIL cmp_addr1: got %h want 102", out_addr_o); end
        checks++; if (out_rdata_o[15:0] !== 16'h0000) begin errors++; $display("FAIL cmp_rdata1: got %h want 0000", out_rdata_o[15:0]); end
        tick();
        #2;
        checks++; if (level_o !== 0) begin errors++; $display("FAIL cmp_pop_level: got %0d want 0", level_o); end
        checks++; if (out_addr_o !== 32'h104) begin errors++; $display("FAIL cmp_addr2: got %h want 104", out_addr_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL cmp_empty_valid: got %b want 0", out_valid_o); end
        out_ready_i = 1'b0;
        do_clear(32'hFFFF_FFFF);
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        in_rdata_i  = 32'h0001_0000;
        #2;
        checks++; if (out_addr_o !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_start_addr: got %h want fffffffe", out_addr_o); end
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b want 1", out_valid_o); end
        tick();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        #2;
        checks++; if (out_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 0", out_addr_o); end
        checks++; if (level_o !== 0) begin errors++; $display("FAIL wrap_level: got %0d want 0", level_o); end
    endtask

    task automatic test_unaligned();
        out_ready_i = 1'b0;
        do_clear(32'h102);
        push_word(32'hABCF_0001, 1'b0);
        #2;
        checks++; if (level_o !== 1) begin errors++; $display("FAIL unal_level: got %0d want 1", level_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL unal_wait_valid: got %b want 0", out_valid_o); end
        in_valid_i = 1'b1;
        in_rdata_i = 32'h0000_1234;
        #2;
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL unal_valid: got %b want 1", out_valid_o); end
        checks++; if (out_rdata_o !== 32'h1234_ABCF) begin errors++; $display("FAIL unal_rdata: got %h want 1234abcf", out_rdata_o); end
        checks++; if (out_err_o !== 1'b0) begin errors++; $display("FAIL unal_err: got %b want 0", out_err_o); end
        out_ready_i = 1'b1;
        tick();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        #2;
        checks++; if (level_o !== 1) begin errors++; $display("FAIL unal_pushpop_level: got %0d want 1", level_o); end
        checks++; if (out_addr_o !== 32'h106) begin errors++; $display("FAIL unal_next_addr: got %h want 106", out_addr_o); end
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL unal_next_valid: got %b want 1", out_valid_o); end
        checks++; if (out_rdata_o[15:0] !== 16'h0000) begin errors++; $display("FAIL unal_next_rdata: got %h want 0000", out_rdata_o[15:0]); end
        do_clear(32'h102);
        push_word(32'hABCD_0001, 1'b0);
        in_valid_i = 1'b1;
        in_rdata_i = 32'h0000_1234;
        #2;
        checks++; if (out_rdata_o !== 32'h1234_ABCD) begin errors++; $display("FAIL unal_rdata2: got %h want 1234abcd", out_rdata_o); end
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL unal_cmp_valid: got %b want 1", out_valid_o); end
        in_valid_i = 1'b0;
    endtask

    task automatic test_overflow();
        int exp_lvl[4]                 = '{1, 2, 3, 3};
        logic exp_ovf[4]               = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [NUM_REQS-1:0] exp_busy[4] = '{2'b00, 2'b01, 2'b11, 2'b11};
        out_ready_i = 1'b0;
        do_clear(32'h0);
        for (int k = 0; k < 4; k++) begin
            push_word($urandom, 1'b0);
            #2;
            checks++; if (level_o !== LVL_W'(exp_lvl[k])) begin errors++; $display("FAIL ovf_level[%0d]: got %0d want %0d", k, level_o, exp_lvl[k]); end
            checks++; if (overflow_o !== exp_ovf[k]) begin errors++; $display("FAIL ovf_flag[%0d]: got %b want %b", k, overflow_o, exp_ovf[k]); end
            checks++; if (busy_o !== exp_busy[k]) begin errors++; $display("FAIL ovf_busy[%0d]: got %b want %b", k, busy_o, exp_busy[k]); end
        end
        do_clear(32'h0);
        #2;
        checks++; if (level_o !== 0) begin errors++; $display("FAIL ovf_clear_level: got %0d want 0", level_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clear_flag: got %b want 0", overflow_o); end
    endtask

    task automatic test_err_plus2();
        out_ready_i = 1'b0;
        do_clear(32'h102);
        push_word(32'hFFFF_0000, 1'b0);
        in_valid_i = 1'b1;
        in_rdata_i = 32'h0000_5678;
        in_err_i   = 1'b1;
        #2;
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL errp2_valid: got %b want 1", out_valid_o); end
        checks++; if (out_err_o !== 1'b1) begin errors++; $display("FAIL errp2_err: got %b want 1", out_err_o); end
        checks++; if (out_err_plus2_o !== 1'b1) begin errors++; $display("FAIL errp2_plus2: got %b want 1", out_err_plus2_o); end
        in_valid_i = 1'b0;
        in_err_i   = 1'b0;
        do_clear(32'h102);
        push_word(32'hFFFF_0000, 1'b1);
        in_valid_i = 1'b1;
        in_rdata_i = 32'h0000_5678;
        #2;
        checks++; if (out_err_o !== 1'b1) begin errors++; $display("FAIL errhead_err: got %b want 1", out_err_o); end
        checks++; if (out_err_plus2_o !== 1'b0) begin errors++; $display("FAIL errhead_plus2: got %b want 0", out_err_plus2_o); end
        in_valid_i = 1'b0;
        do_clear(32'h100);
        in_valid_i = 1'b1;
        in_rdata_i = 32'h0000_0001;
        in_err_i   = 1'b1;
        #2;
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL erral_valid: got %b want 1", out_valid_o); end
        checks++; if (out_err_o !== 1'b1) begin errors++; $display("FAIL erral_err: got %b want 1", out_err_o); end
        checks++; if (out_err_plus2_o !== 1'b0) begin errors++; $display("FAIL erral_plus2: got %b want 0", out_err_plus2_o); end
        in_valid_i = 1'b0;
        in_err_i   = 1'b0;
    endtask

    task automatic test_backup_restore();
        do_clear(32'h200);
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        in_rdata_i  = 32'h0000_0003;
        backup_i    = 1'b1;
        #2;
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL bk_valid: got %b want 1", out_valid_o); end
        tick();
        backup_i    = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        #2;
        checks++; if (out_addr_o !== 32'h204) begin errors++; $display("FAIL bk_advance: got %h want 204", out_addr_o); end
        push_word(32'h0000_0003, 1'b0);
        push_word(32'h0000_0003, 1'b0);
        #2;
        checks++; if (level_o !== 2) begin errors++; $display("FAIL bk_fill_level: got %0d want 2", level_o); end
        restore_i = 1'b1;
        tick();
        restore_i = 1'b0;
        #2;
        checks++; if (out_addr_o !== 32'h204) begin errors++; $display("FAIL restore_addr: got %h want 204", out_addr_o); end
        checks++; if (level_o !== 0) begin errors++; $display("FAIL restore_level: got %0d want 0", level_o); end
        do_clear(32'h400);
        backup_i  = 1'b1;
        restore_i = 1'b1;
        tick();
        backup_i  = 1'b0;
        restore_i = 1'b0;
        #2;
        checks++; if (out_addr_o !== 32'h204) begin errors++; $display("FAIL bkrs_addr: got %h want 204", out_addr_o); end
        do_clear(32'h500);
        restore_i = 1'b1;
        tick();
        restore_i = 1'b0;
        #2;
        checks++; if (out_addr_o !== 32'h204) begin errors++; $display("FAIL bkrs_keep: got %h want 204", out_addr_o); end
    endtask

    task automatic test_clear_restore_reset();
        out_ready_i = 1'b0;
        push_word(32'h1111_1113, 1'b0);
        clear_i    = 1'b1;
        restore_i  = 1'b1;
        in_addr_i  = 32'h300;
        in_valid_i = 1'b1;
        tick();
        clear_i    = 1'b0;
        restore_i  = 1'b0;
        in_valid_i = 1'b0;
        #2;
        checks++; if (out_addr_o !== 32'h300) begin errors++; $display("FAIL clrrs_addr: got %h want 300", out_addr_o); end
        checks++; if (level_o !== 0) begin errors++; $display("FAIL clrrs_level: got %0d want 0", level_o); end
        do_clear(32'h305);
        #2;
        checks++; if (out_addr_o !== 32'h304) begin errors++; $display("FAIL clr_bit0: got %h want 304", out_addr_o); end
        push_word(32'h2222_2223, 1'b0);
        push_word(32'h3333_3333, 1'b0);
        #2;
        checks++; if (level_o !== 2) begin errors++; $display("FAIL midrst_fill: got %0d want 2", level_o); end
        rst_ni      = 1'b0;
        restore_i   = 1'b1;
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        tick();
        rst_ni      = 1'b1;
        restore_i   = 1'b0;
        out_ready_i = 1'b0;
        in_valid_i  = 1'b0;
        #2;
        checks++; if (level_o !== 0) begin errors++; $display("FAIL midrst_level: got %0d want 0", level_o); end
        checks++; if (out_addr_o !== 32'h0) begin errors++; $display("FAIL midrst_addr: got %h want 0", out_addr_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", out_valid_o); end
        restore_i = 1'b1;
        tick();
        restore_i = 1'b0;
        #2;
        checks++; if (out_addr_o !== 32'h0) begin errors++; $display("FAIL midrst_ckpt: got %h want 0", out_addr_o); end
    endtask

    task automatic test_random();
        logic [32:0]         h, n;
        logic [31:0]         m_pc, m_bk, nxt_pc, e_data;
        logic [NUM_REQS-1:0] e_busy;
        bit                  have_h, have_n, un, comp, e_valid, e_err, e_p2, hs, m_ovf;
        idle_inputs();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        exp_q.delete();
        m_pc  = 32'h0;
        m_bk  = 32'h0;
        m_ovf = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            in_valid_i  = ($urandom_range(0, 1) == 1);
            in_rdata_i  = $urandom;
            in_err_i    = ($urandom_range(0, 15) == 0);
            out_ready_i = ((cyc % 64) < 12) ? 1'b0 : ($urandom_range(0, 3) != 0);
            clear_i     = ($urandom_range(0, 39) == 0);
            restore_i   = ($urandom_range(0, 49) == 0);
            backup_i    = ($urandom_range(0, 14) == 0);
            in_addr_i   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            #2;
            // Instruction view: buffered words followed by the incoming word.
            have_h = (exp_q.size() > 0) || in_valid_i;
            h      = (exp_q.size() > 0) ? exp_q[0] : {in_err_i, in_rdata_i};
            have_n = (exp_q.size() > 1) || ((exp_q.size() == 1) && in_valid_i);
            n      = (exp_q.size() > 1) ? exp_q[1] : {in_err_i, in_rdata_i};
            un     = m_pc[1];
            if (!un) begin
                comp    = (h[1:0] != 2'b11) && !h[32];
                e_valid = have_h;
                e_data  = h[31:0];
                e_err   = h[32];
                e_p2    = 1'b0;
            end else begin
                comp    = (h[17:16] != 2'b11) && !h[32];
                e_valid = have_h && (comp || have_n);
                e_data  = {n[15:0], h[31:16]};
                e_err   = comp ? h[32] : (h[32] || n[32]);
                e_p2    = !comp && !h[32] && n[32];
            end
            for (int j = 0; j < NUM_REQS; j++) e_busy[j] = ((DEPTH - NUM_REQS + j) < exp_q.size());
            checks++; if (out_valid_o !== e_valid) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, out_valid_o, e_valid); end
            checks++; if (out_addr_o !== m_pc) begin errors++; $display("FAIL rnd_addr@%0d: got %h want %h", cyc, out_addr_o, m_pc); end
            checks++; if (level_o !== LVL_W'(exp_q.size())) begin errors++; $display("FAIL rnd_level@%0d: got %0d want %0d", cyc, level_o, exp_q.size()); end
            checks++; if (overflow_o !== m_ovf) begin errors++; $display("FAIL rnd_overflow@%0d: got %b want %b", cyc, overflow_o, m_ovf); end
            checks++; if (busy_o !== e_busy) begin errors++; $display("FAIL rnd_busy@%0d: got %b want %b", cyc, busy_o, e_busy); end
            if (e_valid) begin
                checks++; if (out_rdata_o !== e_data) begin errors++; $display("FAIL rnd_rdata@%0d: got %h want %h", cyc, out_rdata_o, e_data); end
                checks++; if (out_err_o !== e_err) begin errors++; $display("FAIL rnd_err@%0d: got %b want %b", cyc, out_err_o, e_err); end
                checks++; if (out_err_plus2_o !== e_p2) begin errors++; $display("FAIL rnd_plus2@%0d: got %b want %b", cyc, out_err_plus2_o, e_p2); end
            end
            hs = e_valid && out_ready_i;
            if (in_valid_i) begin
                if (exp_q.size() < DEPTH) exp_q.push_back({in_err_i, in_rdata_i});
                else if (!clear_i && !restore_i) m_ovf = 1'b1;
            end
            if (hs && (!comp || un)) void'(exp_q.pop_front());
            if (clear_i || restore_i) exp_q.delete();
            if (clear_i) m_ovf = 1'b0;
            if (clear_i) nxt_pc = {in_addr_i[31:1], 1'b0};
            else if (restore_i) nxt_pc = m_bk;
            else if (hs) nxt_pc = m_pc + (comp ? 32'd2 : 32'd4);
            else nxt_pc = m_pc;
            if (backup_i && !restore_i) m_bk = nxt_pc;
            m_pc = nxt_pc;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_ni = 1'b0;
        test_reset();
        test_compressed();
        test_unaligned();
        test_overflow();
        test_err_plus2();
        test_backup_restore();
        test_clear_restore_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
